// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_pkg
// Description : Shared types and constants for the serial 11101 detector:
//               detector state encoding, controller state encoding and the
//               pattern itself.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    // Detector progress through the pattern: S0 = nothing, S4 = "1110" seen
    typedef enum logic [2:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100
    } det_state_t;

    // Word serializer controller
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ctrl_state_t;

    // Pattern searched for in the serial bit stream (MSB is the oldest bit)
    localparam logic [4:0] c_pattern = 5'b11101;

endpackage
`default_nettype wire

// File: rtl/seq_det_core.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_core
// Description : Mealy recogniser for the 11101 pattern. The state only moves
//               when bit_en is high; match is the unregistered Mealy output
//               that flags "this enabled bit completes the pattern" and is
//               registered by the enclosing controller.
//               Build option: define SEQ_OVERLAP_EN to let the final 1 of a
//               match start the next pattern (overlapping detection).
// Revision    : 1.0 - initial release
// ============================================================================
module seq_det_core
    import seq_det_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic bit_en,
    input  logic bit_in,
    output logic match
);

    det_state_t r_state;
    det_state_t w_state_next;

    // The last step of the pattern is S4 receiving the final pattern bit
    assign match = bit_en && (r_state == S4) && (bit_in == c_pattern[0]);

    // Next-state table for one consumed bit
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S0: w_state_next = bit_in ? S1 : S0;
            S1: w_state_next = bit_in ? S2 : S0;
            S2: w_state_next = bit_in ? S3 : S0;
            S3: w_state_next = bit_in ? S3 : S4;
            S4: begin
`ifdef SEQ_OVERLAP_EN
                // The completing 1 doubles as the first bit of the next pattern
                w_state_next = bit_in ? S1 : S0;
`else
                w_state_next = S0;
`endif
            end
            default: w_state_next = S0;
        endcase
    end

    // State register; holds across words so patterns may straddle them
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S0;
        end else if (bit_en) begin
            r_state <= w_state_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_ctrl
// Description : Accepts DATA_W-bit words, serializes them MSB-first into the
//               11101 detector, counts matches (saturating) and raises a
//               sticky irq when the count reaches a programmable threshold.
//               Build option: SEQ_OVERLAP_EN (see seq_det_core).
// Revision    : 1.0 - initial release
// ============================================================================
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [CNT_W-1:0]  thresh,
    input  logic              clr,
    output logic              busy,
    output logic              match,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              irq
);

    localparam int c_bit_w = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    ctrl_state_t        r_state;
    logic [DATA_W-1:0]  r_shreg;
    logic [c_bit_w-1:0] r_bitcnt;
    logic               r_in_ready;
    logic               r_busy;
    logic               r_match;
    logic [CNT_W-1:0]   r_match_cnt;
    logic               r_irq;

    logic               w_bit_en;
    logic               w_bit_in;
    logic               w_hit;
    logic [CNT_W-1:0]   w_cnt_next;

    assign w_bit_en = (r_state == SHIFT);
    assign w_bit_in = r_shreg[DATA_W-1];

    seq_det_core u_core (
        .clk    (clk),
        .reset  (reset),
        .bit_en (w_bit_en),
        .bit_in (w_bit_in),
        .match  (w_hit)
    );

    // Count value after this hit, held at all-ones instead of wrapping
    assign w_cnt_next = (&r_match_cnt) ? r_match_cnt : r_match_cnt + 1'b1;

    // Serializer: one load cycle in IDLE, then DATA_W shift cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_bitcnt   <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_shreg    <= in_data;
                        r_bitcnt   <= c_bit_w'(DATA_W - 1);
                        r_state    <= SHIFT;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    r_shreg <= r_shreg << 1;
                    if (r_bitcnt == '0) begin
                        // Bit on the detector this cycle is the word's last
                        r_state    <= IDLE;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end else begin
                        r_bitcnt <= r_bitcnt - 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    // Match pulse, saturating counter and sticky irq; clr wins over a hit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_match     <= 1'b0;
            r_match_cnt <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_match <= w_hit;
            if (clr) begin
                r_match_cnt <= '0;
                r_irq       <= 1'b0;
            end else if (w_hit) begin
                r_match_cnt <= w_cnt_next;
                // Only a counting edge can reach the threshold, so lowering
                // thresh beneath the current count never fires irq
                if ((thresh != '0) && (w_cnt_next == thresh)) begin
                    r_irq <= 1'b1;
                end
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign match     = r_match;
    assign match_cnt = r_match_cnt;
    assign irq       = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_det_ctrl
// Description : Self-checking bench for seq_det_ctrl. A bit-stream model
//               (last five bits vs. 11101) predicts every output each cycle;
//               directed word scenarios add hand-computed expectations.
//               Honors SEQ_OVERLAP_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_det_ctrl;

`ifdef SEQ_OVERLAP_EN
    localparam bit c_ovl = 1'b1;
`else
    localparam bit c_ovl = 1'b0;
`endif

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic [7:0] thresh   = 8'h00;
    logic [1:0] thresh2  = 2'b00;
    logic       clr      = 1'b0;

    logic       in_ready, busy, match, irq;
    logic [7:0] match_cnt;
    logic       in_ready2, busy2, match2, irq2;
    logic [1:0] match_cnt2;

    seq_det_ctrl #(.DATA_W(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .thresh(thresh), .clr(clr), .busy(busy),
        .match(match), .match_cnt(match_cnt), .irq(irq)
    );

    seq_det_ctrl #(.DATA_W(8), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready2), .thresh(thresh2), .clr(clr), .busy(busy2),
        .match(match2), .match_cnt(match_cnt2), .irq(irq2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_left  = 0;      // bits of the current word still to consume
    logic [7:0] m_word  = 8'h00;
    logic [4:0] m_hist  = 5'b0;   // last five consumed bits, newest in bit 0
    int         m_since = 99;     // bits consumed since the last match
    logic       m_match = 1'b0;
    int         m_cnt   = 0;
    int         m_cnt2  = 0;
    logic       m_irq   = 1'b0;
    logic       m_irq2  = 1'b0;
    int         m_nxt;

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_left = 0; m_word = 8'h00; m_hist = 5'b0; m_since = 99;
                m_match = 1'b0; m_cnt = 0; m_cnt2 = 0; m_irq = 1'b0; m_irq2 = 1'b0;
            end else begin
                m_match = 1'b0;
                if (m_left > 0) begin
                    m_hist  = {m_hist[3:0], m_word[m_left-1]};
                    m_since = m_since + 1;
                    if (m_hist == 5'b11101 && (c_ovl || m_since >= 5)) begin
                        m_match = 1'b1;
                        m_since = 0;
                    end
                    m_left = m_left - 1;
                end else if (in_valid) begin
                    m_word = in_data;
                    m_left = 8;
                end
                if (clr) begin
                    m_cnt = 0; m_irq = 1'b0; m_cnt2 = 0; m_irq2 = 1'b0;
                end else if (m_match) begin
                    m_nxt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
                    if (thresh != 0 && m_nxt == thresh) m_irq = 1'b1;
                    m_cnt = m_nxt;
                    m_nxt = (m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1;
                    if (thresh2 != 0 && m_nxt == thresh2) m_irq2 = 1'b1;
                    m_cnt2 = m_nxt;
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model
    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("in_ready",   in_ready,   (m_left == 0));
            check("busy",       busy,       (m_left != 0));
            check("match",      match,      m_match);
            check("match_cnt",  match_cnt,  m_cnt);
            check("irq",        irq,        m_irq);
            check("in_ready2",  in_ready2,  (m_left == 0));
            check("busy2",      busy2,      (m_left != 0));
            check("match2",     match2,     m_match);
            check("match_cnt2", match_cnt2, m_cnt2);
            check("irq2",       irq2,       m_irq2);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_word(input logic [7:0] w, output int lowc, output int at, output int n);
        int t;
        lowc = 0; at = -1; n = 0; t = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (in_ready !== 1'b1) begin
            check("ready_timeout", 0, 1);
            return;
        end
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (in_ready !== 1'b1) lowc++;
        if (match === 1'b1) begin n++; at = 0; end
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (match === 1'b1) begin n++; at = k; end
            if (in_ready === 1'b1) break;
            lowc++;
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    int lowc, at, n, rdy;

    initial begin
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_cnt", match_cnt, 0);
        check("rst_irq", irq, 0);

        // Single word with one pattern at its head
        send_word(8'b11101000, lowc, at, n);
        check("w1_ready_low_cycles", lowc, 8);
        check("w1_match_cycle", at, 5);
        check("w1_match_count", n, 1);
        check("w1_cnt", match_cnt, 1);
        pulse_clr();
        check("clr_cnt", match_cnt, 0);

        // Pattern straddling a word boundary only in overlapping mode
        send_word(8'b11110111, lowc, at, n);
        check("w2a_matches", n, 1);
        send_word(8'b01000000, lowc, at, n);
        check("w2b_matches", n, c_ovl ? 1 : 0);
        check("w2_cnt", match_cnt, c_ovl ? 2 : 1);
        pulse_clr();

        // Threshold irq and its clearing
        @(negedge clk); thresh = 8'd3;
        send_word(8'b11101111, lowc, at, n);
        check("t_cnt1", match_cnt, 1);
        check("t_irq1", irq, 0);
        send_word(8'b01000000, lowc, at, n);
        check("t_cnt2", match_cnt, 2);
        check("t_irq2", irq, 0);
        send_word(8'b11101000, lowc, at, n);
        check("t_cnt3", match_cnt, 3);
        check("t_irq3", irq, 1);
        repeat (4) @(negedge clk);
        check("t_irq_sticky", irq, 1);
        pulse_clr();
        check("t_clr_cnt", match_cnt, 0);
        check("t_clr_irq", irq, 0);
        thresh = 8'd0;

        // clr held across a match: pulse still fires, count stays zero
        @(negedge clk); clr = 1'b1;
        send_word(8'b11101000, lowc, at, n);
        check("clr_hit_pulse", n, 1);
        check("clr_hit_cnt", match_cnt, 0);
        @(negedge clk); clr = 1'b0;

        // Saturation of the 2-bit counter; 8-bit counter keeps counting
        thresh2 = 2'd2;
        for (int i = 0; i < 5; i++) send_word(8'b11101000, lowc, at, n);
        check("sat_cnt2", match_cnt2, 3);
        check("sat_irq2", irq2, 1);
        check("sat_cnt8", match_cnt, 5);

        // Lowering thresh beneath the count must not raise irq
        @(negedge clk); thresh = 8'd2;
        repeat (3) @(negedge clk);
        check("low_thresh_irq_a", irq, 0);
        send_word(8'b11101000, lowc, at, n);
        check("low_thresh_cnt", match_cnt, 6);
        check("low_thresh_irq_b", irq, 0);
        @(negedge clk); thresh = 8'd0;

        // Back-to-back words: one ready cycle per DATA_W+1
        @(negedge clk); in_valid = 1'b1; in_data = 8'h00;
        @(posedge clk); #1;
        rdy = 0;
        for (int k = 1; k <= 27; k++) begin
            @(posedge clk); #1;
            if (in_ready === 1'b1) rdy++;
        end
        in_valid = 1'b0;
        check("b2b_ready_cycles", rdy, 3);
        send_word(8'h00, lowc, at, n);

        // Asynchronous reset on the 4th bit, then a clean word
        @(negedge clk); in_valid = 1'b1; in_data = 8'b11101000;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #2 reset = 1'b0;
        #1;
        check("async_in_ready", in_ready, 1);
        check("async_busy", busy, 0);
        check("async_match", match, 0);
        check("async_cnt", match_cnt, 0);
        check("async_irq", irq, 0);
        @(negedge clk); reset = 1'b1;
        send_word(8'b00011101, lowc, at, n);
        check("post_rst_matches", n, 1);
        check("post_rst_cnt", match_cnt, 1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, meaning width of each parallel input word serialized MSB-first.
REQ-002 Parameter CNT_W, default 8, meaning width of match counter and threshold.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  input word valid.
REQ-006 in_data  input  DATA_W  input word.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 thresh  input  CNT_W  irq threshold; 0 disables irq.
REQ-009 clr  input  1  synchronous clear of match_cnt and irq.
REQ-010 busy  output  1  high while serializing a word.
REQ-011 match  output  1  one-cycle pulse per detected 11101 pattern.
REQ-012 match_cnt  output  CNT_W  number of matches since reset or clr.
REQ-013 irq  output  1  sticky threshold-reached flag.

Function
REQ-014 Controller FSM SHALL have states IDLE and SHIFT; in_ready=1 only in IDLE; busy=1 only in SHIFT.
REQ-015 In IDLE, in_valid=1 SHALL load in_data into the shift register, load bit counter with DATA_W-1, and move to SHIFT on the same edge.
REQ-016 In SHIFT, each cycle SHALL present shift-register MSB to the detector with bit_en=1, shift left by one and decrement the counter; when the counter is 0, that bit is the last and FSM SHALL return to IDLE.
REQ-017 Throughput SHALL be DATA_W+1 cycles per word under back-to-back in_valid; in_valid in SHIFT is ignored.
REQ-018 Detector SHALL be Mealy with states S0 (none), S1 ("1"), S2 ("11"), S3 ("111"), S4 ("1110"); advances only when bit_en=1.
REQ-019 Transitions: S0: 1->S1, 0->S0; S1: 1->S2, 0->S0; S2: 1->S3, 0->S0; S3: 1->S3, 0->S4; S4: 0->S0, 1->match.
REQ-020 Detector state SHALL persist across words, so patterns spanning word boundaries are detected.
REQ-021 match SHALL be registered: high for exactly the one cycle following the edge that consumes the completing bit.
REQ-022 match_cnt SHALL increment on the same edge match rises and saturate at all-ones (no wrap).
REQ-023 irq SHALL set on the edge where the next match_cnt value equals thresh and thresh!=0, and remain set until clr or reset.
REQ-024 clr SHALL take priority: match_cnt->0 and irq->0 even on a coincident match; the match pulse still fires.
REQ-025 Changing thresh below current match_cnt SHALL NOT set irq.

Reset
REQ-026 Asynchronous assertion of reset (low) SHALL force FSM=IDLE, detector=S0, shift register=0, counter=0, in_ready=1, busy=0, match=0, match_cnt=0, irq=0, including mid-word; the partial word is discarded.
REQ-027 Normal operation SHALL resume on the first rising clk edge after reset deasserts.

Configuration
REQ-028 Macro SEQ_OVERLAP_EN defined: S4 with input 1 SHALL signal match and go to S1 (overlapping detection).
REQ-029 SEQ_OVERLAP_EN undefined: S4 with input 1 SHALL signal match and go to S0 (non-overlapping).

Structure
REQ-030 Shared package seq_det_pkg SHALL hold the detector state typedef (S0..S4, 3-bit encoding 000..100), the controller state typedef, and the pattern constant 5'b11101.
REQ-031 Detector SHALL be a sub-module seq_det_core (ports clk, reset, bit_en, bit_in, match); seq_det_ctrl holds FSM, shift register, counter and irq logic.

Verification
REQ-032 Word 8'b11101000 after reset -> in_ready low 8 cycles, single match pulse in the cycle after the 5th bit is consumed, match_cnt=1.
REQ-033 Words 8'b11110111 then 8'b01000000 -> SEQ_OVERLAP_EN: match_cnt=2 (second spans words); undefined: match_cnt=1.
REQ-034 thresh=3, stream of words 8'b11101111, 8'b01000000, 8'b11101000 -> irq rises on the edge match_cnt becomes 3, stays high; clr pulse -> match_cnt=0, irq=0.
REQ-035 CNT_W=2, five 8'b11101000 words -> match_cnt saturates at 3, no wrap to 0.
REQ-036 Assert reset on the 4th bit of 8'b11101000 -> all outputs at reset values immediately; next word 8'b00011101 -> exactly one match.
